tx_iq_sample_pacer: RTL and testbench

TX_IQ_SAMPLE_PACER -- requirements
Module: tx_iq_sample_pacer

---
 rtl/tx_pacer_pkg.sv | 20 ++
 rtl/tx_iq_sample_pacer_if.sv | 15 +
 rtl/tx_pacer_divider.sv | 38 +++
 rtl/tx_iq_sample_pacer.sv | 143 ++++++++++++++
 tb/tb_tx_iq_sample_pacer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_pacer_pkg.sv
// Shared types and constants for the TX IQ sample pacer.
// Build option: TXPACER_UNDERFLOW_CNT_EN enables the saturating underflow event counter.
package tx_pacer_pkg;

  localparam int IQW_DEFAULT = 24;
  localparam int DIVIDE_P2   = 640;
  localparam int UCNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pacer_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tx_iq_sample_pacer_if.sv
// Sample stream between the modulator (master) and the pacer (slave).
// Build option: TXPACER_UNDERFLOW_CNT_EN has no effect on this interface.
interface tx_iq_sample_pacer_if #(
  parameter int IQW = tx_pacer_pkg::IQW_DEFAULT
);
  // A sample moves on a cycle where tvalid and tready are both high. tready is a
  // one-cycle request pulse that never waits for tvalid; tdata/tvalid are only
  // looked at while tready is high, so the master may change them freely otherwise.
  logic [2*IQW-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/tx_pacer_divider.sv
// Free-running modulo-DIVIDE counter with a terminal-count flag and a synchronous hold to zero.
// Build option: TXPACER_UNDERFLOW_CNT_EN has no effect on this block.
module tx_pacer_divider #(
  parameter int DIVIDE = 640
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tc
);

  localparam int              CW   = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (hold) begin
      count_d = '0;
    end else if (tc) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tx_iq_sample_pacer.sv
// Paces modulator IQ samples to the DUC at one sample every DIVIDE clocks, zero-filling on underflow.
// Build option: define TXPACER_UNDERFLOW_CNT_EN to implement UnderflowCount; otherwise it reads 0.
module tx_iq_sample_pacer
  import tx_pacer_pkg::*;
#(
  parameter int DIVIDE = DIVIDE_P2,
  parameter int IQW    = IQW_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             TX_ENABLE,
  input  logic [2*IQW-1:0] s_axis_TXMod_tdata,
  input  logic             s_axis_TXMod_tvalid,
  output logic             s_axis_TXMod_tready,
  input  logic             UnderflowClear,
  output logic [IQW-1:0]   DAC_I,
  output logic [IQW-1:0]   DAC_Q,
  output logic             SampleStrobe,
  output logic             Underflow,
  output logic [15:0]      UnderflowCount,
  output logic             PacerActive,
  output pacer_state_e     dbg_state
);

  pacer_state_e   state_q, state_d;
  logic [IQW-1:0] dac_i_q, dac_i_d, dac_q_q, dac_q_d;
  logic           strobe_q, strobe_d;
  logic           uf_q, uf_d;
  logic           active_q, active_d;
  logic           hold, tc, pulse;

  // Counter sits at 0 in IDLE and is already zero on the first cycle back in IDLE.
  assign hold = (state_q == IDLE) || !TX_ENABLE;

  tx_pacer_divider #(.DIVIDE(DIVIDE)) u_div (
    .clk   (aclk),
    .rst_n (aresetn),
    .hold  (hold),
    .tc    (tc)
  );

  assign pulse               = (state_q != IDLE) && TX_ENABLE && tc;
  assign s_axis_TXMod_tready = pulse;

  always_comb begin
    state_d  = state_q;
    dac_i_d  = dac_i_q;
    dac_q_d  = dac_q_q;
    strobe_d = 1'b0;
    uf_d     = uf_q;
    if (!TX_ENABLE) begin
      state_d = IDLE;
      dac_i_d = '0;
      dac_q_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          // Empty request pulses while priming are expected, not underflows.
          if (pulse && s_axis_TXMod_tvalid) begin
            dac_i_d  = s_axis_TXMod_tdata[2*IQW-1:IQW];
            dac_q_d  = s_axis_TXMod_tdata[IQW-1:0];
            strobe_d = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (pulse) begin
            strobe_d = 1'b1;
            if (s_axis_TXMod_tvalid) begin
              dac_i_d = s_axis_TXMod_tdata[2*IQW-1:IQW];
              dac_q_d = s_axis_TXMod_tdata[IQW-1:0];
            end else begin
              dac_i_d = '0;
              dac_q_d = '0;
              uf_d    = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (UnderflowClear) begin
      uf_d = 1'b0;
    end
    active_d = (state_d == RUN);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      dac_i_q  <= '0;
      dac_q_q  <= '0;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dac_i_q  <= dac_i_d;
      dac_q_q  <= dac_q_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
      active_q <= active_d;
    end
  end

`ifdef TXPACER_UNDERFLOW_CNT_EN
  logic              uf_evt;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  assign uf_evt = pulse && (state_q == RUN) && !s_axis_TXMod_tvalid;

  // A clear in the same cycle as an underflow leaves the count at zero.
  always_comb begin
    ucnt_d = ucnt_q;
    if (UnderflowClear) begin
      ucnt_d = '0;
    end else if (uf_evt) begin
      ucnt_d = sat_inc(ucnt_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign UnderflowCount = ucnt_q;
`else
  assign UnderflowCount = '0;
`endif

  assign DAC_I        = dac_i_q;
  assign DAC_Q        = dac_q_q;
  assign SampleStrobe = strobe_q;
  assign Underflow    = uf_q;
  assign PacerActive  = active_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tx_iq_sample_pacer.sv
// Bench for tx_iq_sample_pacer: directed scenarios plus random traffic against a period-arithmetic model.
// Expectations for UnderflowCount follow TXPACER_UNDERFLOW_CNT_EN.
`timescale 1ns/1ps
module tb_tx_iq_sample_pacer;
  import tx_pacer_pkg::*;

  localparam int DIV = 640;
  localparam int IQW = 24;
  localparam int W   = 2*IQW;
`ifdef TXPACER_UNDERFLOW_CNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int N2     = 70000;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int N2     = 3000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tx_enable, uf_clear;
  tx_iq_sample_pacer_if #(.IQW(IQW)) axis();
  logic [IQW-1:0] dac_i, dac_q;
  logic           strobe, uf, active;
  logic [15:0]    ucnt;
  pacer_state_e   dbg;

  tx_iq_sample_pacer #(.DIVIDE(DIV), .IQW(IQW)) u_dut (
    .aclk                (clk),
    .aresetn             (rst_n),
    .TX_ENABLE           (tx_enable),
    .s_axis_TXMod_tdata  (axis.tdata),
    .s_axis_TXMod_tvalid (axis.tvalid),
    .s_axis_TXMod_tready (axis.tready),
    .UnderflowClear      (uf_clear),
    .DAC_I               (dac_i),
    .DAC_Q               (dac_q),
    .SampleStrobe        (strobe),
    .Underflow           (uf),
    .UnderflowCount      (ucnt),
    .PacerActive         (active),
    .dbg_state           (dbg)
  );

  // Second instance with a one-clock period for the saturation run.
  logic           rst2_n, en2, tv2, tr2, st2, uf2, act2;
  logic [W-1:0]   td2;
  logic [IQW-1:0] di2, dq2;
  logic [15:0]    ucnt2;
  pacer_state_e   dbg2;

  tx_iq_sample_pacer #(.DIVIDE(1), .IQW(IQW)) u_dut2 (
    .aclk                (clk),
    .aresetn             (rst2_n),
    .TX_ENABLE           (en2),
    .s_axis_TXMod_tdata  (td2),
    .s_axis_TXMod_tvalid (tv2),
    .s_axis_TXMod_tready (tr2),
    .UnderflowClear      (1'b0),
    .DAC_I               (di2),
    .DAC_Q               (dq2),
    .SampleStrobe        (st2),
    .Underflow           (uf2),
    .UnderflowCount      (ucnt2),
    .PacerActive         (act2),
    .dbg_state           (dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pulses fall on every DIV-th cycle counted from PRIME entry; outputs follow one cycle after.
  int             cyc, m_start, m_mode;  // m_mode: 0 idle, 1 priming, 2 running
  logic [IQW-1:0] e_i, e_q;
  logic           e_strobe, e_uf;
  int             e_ucnt;

  function automatic bit model_pulse();
    return (m_mode != 0) && tx_enable && (((cyc - m_start) % DIV) == DIV - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_start = 0; m_mode = 0;
      e_i = '0; e_q = '0; e_strobe = 1'b0; e_uf = 1'b0; e_ucnt = 0;
    end else begin
      bit p;
      p = model_pulse();
      e_strobe = 1'b0;
      if (!tx_enable) begin
        m_mode = 0; e_i = '0; e_q = '0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_start = cyc + 1;
      end else if (p) begin
        if (axis.tvalid) begin
          e_i = axis.tdata[W-1:IQW]; e_q = axis.tdata[IQW-1:0];
          e_strobe = 1'b1; m_mode = 2;
        end else if (m_mode == 2) begin
          e_i = '0; e_q = '0; e_strobe = 1'b1; e_uf = 1'b1;
          if (e_ucnt < 65535) e_ucnt++;
        end
      end
      if (uf_clear) begin e_uf = 1'b0; e_ucnt = 0; end
      cyc++;
    end
  end

  int strobe_cnt = 0;
  always @(negedge clk) begin
    check("tready",       64'(axis.tready), 64'(model_pulse()));
    check("dac_i",        64'(dac_i),       64'(e_i));
    check("dac_q",        64'(dac_q),       64'(e_q));
    check("strobe",       64'(strobe),      64'(e_strobe));
    check("underflow",    64'(uf),          64'(e_uf));
    check("uf_count",     64'(ucnt),        CNT_EN ? 64'(e_ucnt) : 64'd0);
    check("pacer_active", 64'(active),      64'(m_mode == 2));
    if (strobe) strobe_cnt++;
  end

  // Model for the DIVIDE=1 instance: every active cycle is a request pulse.
  int m2 = 0;
  int n2_uf = 0;
  always @(posedge clk) begin
    if (!rst2_n) m2 = 0;
    else if (!en2) m2 = 0;
    else if (m2 == 0) m2 = 1;
    else if (tv2) m2 = 2;
    else if (m2 == 2) n2_uf++;
  end

  function automatic logic [63:0] exp_ucnt2();
    if (!CNT_EN) return 64'd0;
    return (n2_uf > 65535) ? 64'd65535 : 64'(n2_uf);
  endfunction

  // ---------------- drivers ----------------
  int bench_cyc = 0;
  always @(posedge clk) bench_cyc++;

  logic rand_data = 1'b1;
  always @(posedge clk) begin
    logic [63:0] r;
    #1;
    if (rand_data) begin
      r = {$urandom(), $urandom()};
      axis.tdata = r[W-1:0];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that consumes the next request pulse.
  task automatic wait_pulse(input string tag);
    int k;
    k = 0;
    while (k < 2*DIV) begin
      @(negedge clk);
      if (axis.tready) break;
      k++;
    end
    if (k == 2*DIV) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no tready within %0d cycles, required one", tag, 2*DIV);
    end
    @(posedge clk); #1;
  endtask

  logic done2 = 1'b0;
  initial begin
    rst2_n = 1'b0; en2 = 1'b0; tv2 = 1'b1; td2 = '0;
    tick(3);
    rst2_n = 1'b1; en2 = 1'b1;
    tick(3);
    tv2 = 1'b0;
    tick(1000);
    check("sat_mid_count", 64'(ucnt2), exp_ucnt2());
    tick(N2 - 1000);
    en2 = 1'b0;
    tick(1);
    check("sat_final_count", 64'(ucnt2), exp_ucnt2());
    check("sat_flag",        64'(uf2),   64'd1);
    done2 = 1'b1;
  end

  // ---------------- directed + random sequence ----------------
  int k, off;
  int pt[10];
  int s_before;

  initial begin
    rst_n = 1'b0; tx_enable = 1'b0; uf_clear = 1'b0;
    axis.tvalid = 1'b0; axis.tdata = '0;
    tick(3);
    check("reset_dac_i",  64'(dac_i),  64'd0);
    check("reset_ucnt",   64'(ucnt),   64'd0);
    check("reset_active", 64'(active), 64'd0);

    // First sample: pulse at offset 639 from PRIME entry, data out one cycle later.
    rand_data = 1'b0;
    axis.tdata = 48'h123456_FEDCBA; axis.tvalid = 1'b1; tx_enable = 1'b1;
    rst_n = 1'b1;
    tick(1);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (axis.tready) break;
      k++;
    end
    check("first_pulse_offset", 64'(k), 64'd639);
    tick(1);
    check("first_dac_i",  64'(dac_i),  64'h123456);
    check("first_dac_q",  64'(dac_q),  64'hFEDCBA);
    check("first_strobe", 64'(strobe), 64'd1);
    check("first_active", 64'(active), 64'd1);

    // Ten samples back to back.
    rand_data = 1'b1;
    @(negedge clk); #1;
    s_before = strobe_cnt;
    for (int s = 0; s < 10; s++) begin
      wait_pulse("run10");
      pt[s] = bench_cyc;
    end
    @(negedge clk); #1;
    for (int s = 1; s < 10; s++) check("pulse_spacing", 64'(pt[s] - pt[s-1]), 64'd640);
    check("ten_strobes",    64'(strobe_cnt - s_before), 64'd10);
    check("run10_no_uf",    64'(uf), 64'd0);

    // Three missing samples, then clear.
    tick(1);
    axis.tvalid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_pulse("underflow3");
      check("uf_dac_i",   64'(dac_i),  64'd0);
      check("uf_dac_q",   64'(dac_q),  64'd0);
      check("uf_strobe",  64'(strobe), 64'd1);
    end
    axis.tvalid = 1'b1;
    check("uf_flag_set", 64'(uf),   64'd1);
    check("uf_count_3",  64'(ucnt), CNT_EN ? 64'd3 : 64'd0);
    uf_clear = 1'b1; tick(1); uf_clear = 1'b0;
    check("uf_cleared_flag",  64'(uf),   64'd0);
    check("uf_cleared_count", 64'(ucnt), 64'd0);

    // Clear landing on the same cycle as an underflow.
    wait_pulse("clr_align");
    tick(DIV - 1);
    axis.tvalid = 1'b0; uf_clear = 1'b1;
    tick(1);
    uf_clear = 1'b0; axis.tvalid = 1'b1;
    check("clr_race_strobe", 64'(strobe), 64'd1);
    check("clr_race_flag",   64'(uf),     64'd0);
    check("clr_race_count",  64'(ucnt),   64'd0);

    // Disable mid-period, re-prime with no data.
    wait_pulse("dis_align");
    tick(300);
    tx_enable = 1'b0;
    tick(1);
    check("dis_state",  64'(dbg),    64'(IDLE));
    check("dis_active", 64'(active), 64'd0);
    check("dis_dac_i",  64'(dac_i),  64'd0);
    axis.tvalid = 1'b0;
    tick(700);
    tx_enable = 1'b1;
    wait_pulse("prime_empty1");
    wait_pulse("prime_empty2");
    check("prime_no_uf",     64'(uf),     64'd0);
    check("prime_not_run",   64'(active), 64'd0);
    axis.tvalid = 1'b1;
    wait_pulse("prime_capture");
    check("prime_to_run", 64'(active), 64'd1);

    // Random traffic: valid gaps, clears and short disables.
    off = 0;
    for (int c = 0; c < 8000; c++) begin
      axis.tvalid = ($urandom_range(0, 1) == 1);
      uf_clear    = ($urandom_range(0, 399) == 0);
      if (off > 0) off--;
      else if ($urandom_range(0, 1499) == 0) off = $urandom_range(1, 40);
      tx_enable = (off == 0);
      tick(1);
    end
    tx_enable = 1'b1; axis.tvalid = 1'b1; uf_clear = 1'b0;

    // Asynchronous reset at count 500 in RUN.
    wait_pulse("rst_align1");
    wait_pulse("rst_align2");
    tick(500);
    check("pre_rst_active", 64'(active), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dac_i",  64'(dac_i),       64'd0);
    check("async_rst_dac_q",  64'(dac_q),       64'd0);
    check("async_rst_active", 64'(active),      64'd0);
    check("async_rst_tready", 64'(axis.tready), 64'd0);
    check("async_rst_flag",   64'(uf),          64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_state", 64'(dbg), 64'(PRIME));
    wait_pulse("post_rst_capture");
    check("post_rst_run", 64'(active), 64'd1);
    tick(5);

    for (int i = 0; i < 100000 && !done2; i++) @(posedge clk);
    if (!done2) begin
      n_checks++; n_fail++;
      $display("FAIL sat_run_done: got 0 expected 1");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
